// File: rtl/mem_stage_if.sv
// Bus bundle for the memory pipeline stage: stall vector, the
// execute-to-memory bus and SRAM read data in; writeback bus and
// decode bypass out.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_WD     = 6
);
    logic [STALL_WD-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [37:0]             mem_to_id_fwd;

    // Surrounding pipeline side
    modport master (
        output stall,
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_id_fwd
    );

    // Memory stage side
    modport slave (
        input  stall,
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_id_fwd
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute-to-memory bus, aligns load
// data from a synchronous SRAM and keeps the first-cycle read word in a
// buffer so a stalled load keeps returning the same value.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_WD     = 6
) (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus
);
    logic [EX_TO_MEM_WD-1:0] stage_r;
    logic                    first_cyc;
    logic                    buf_valid;
    logic [31:0]             rdata_buf;

    logic        hold;
    logic        bubble;
    logic        stall_unused;

    logic [31:0] pc;
    logic [2:0]  ld_type;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        is_load;

    logic [31:0] rdata_eff;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    // Only bits 3 (self) and 4 (writeback) of the stall vector matter here
    assign hold         = bus.stall[3] & bus.stall[4];
    assign bubble       = bus.stall[3] & ~bus.stall[4];
    assign stall_unused = ^bus.stall;

    assign pc           = stage_r[78:47];
    assign ld_type      = stage_r[46:44];
    assign data_ram_en  = stage_r[43];
    assign data_ram_wen = stage_r[42:39];
    assign sel_rf_res   = stage_r[38];
    assign rf_we        = stage_r[37];
    assign rf_waddr     = stage_r[36:32];
    assign ex_result    = stage_r[31:0];
    assign is_load      = data_ram_en & (data_ram_wen == 4'b0000);

    // Stage register: bubble on self-stall only, load when not stalled, else hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_r <= '0;
        end else if (bubble) begin
            stage_r <= '0;
        end else if (!bus.stall[3]) begin
            stage_r <= bus.ex_to_mem_bus;
        end
    end

    // first_cyc marks the cycle right after any new content (including a bubble)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            first_cyc <= 1'b0;
        end else begin
            first_cyc <= ~hold;
        end
    end

    // Capture the SRAM word on a load's first cycle; validity drops on new content
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf <= '0;
            buf_valid <= 1'b0;
        end else begin
            if (first_cyc && is_load) begin
                rdata_buf <= bus.data_sram_rdata;
            end
            if (!hold) begin
                buf_valid <= 1'b0;
            end else if (first_cyc && is_load) begin
                buf_valid <= 1'b1;
            end
        end
    end

    // Load alignment and writeback data selection
    always_comb begin
        rdata_eff = buf_valid ? rdata_buf : bus.data_sram_rdata;
        case (ex_result[1:0])
            2'd0:    byte_sel = rdata_eff[7:0];
            2'd1:    byte_sel = rdata_eff[15:8];
            2'd2:    byte_sel = rdata_eff[23:16];
            default: byte_sel = rdata_eff[31:24];
        endcase
        half_sel = ex_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];
        case (ld_type)
            3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    load_data = {24'b0, byte_sel};
            3'd3:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_data = {16'b0, half_sel};
            default: load_data = rdata_eff;
        endcase
        rf_wdata = sel_rf_res ? load_data : ex_result;
    end

    assign bus.mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign bus.mem_to_id_fwd = {rf_we, rf_waddr, rf_wdata};
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic compared
// against a behavioural model of the stage.
module tb_mem_stage;
    localparam logic [5:0] S_RUN  = 6'b000000;
    localparam logic [5:0] S_HOLD = 6'b011000;
    localparam logic [5:0] S_BUB  = 6'b001000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if #(.EX_TO_MEM_WD(79), .MEM_TO_WB_WD(70), .STALL_WD(6)) bus_if ();

    mem_stage #(.EX_TO_MEM_WD(79), .MEM_TO_WB_WD(70), .STALL_WD(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Model state: instruction in the stage, cycles it has been there,
    // and the read word seen in its first cycle.
    logic [78:0] m_cur;
    int          m_age;
    logic [31:0] m_word;

    logic [69:0] obs_bus;
    logic [37:0] obs_fwd;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] ld,
                                       input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {pc, ld, en, wen, sel, we, wa, res};
    endfunction

    function automatic logic [31:0] ref_align(input logic [2:0] t, input logic [1:0] a,
                                              input logic [31:0] w);
        logic [31:0] v;
        case (t)
            3'd1, 3'd2: begin
                v = (w >> (int'(a) * 8)) & 32'hFF;
                if (t == 3'd1 && v >= 32'd128) v = v - 32'd256;
            end
            3'd3, 3'd4: begin
                v = (w >> (int'(a[1]) * 16)) & 32'hFFFF;
                if (t == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [69:0] model_out(input logic [31:0] rd);
        logic [31:0] word;
        logic [31:0] wdata;
        logic        load;
        load  = m_cur[43] && (m_cur[42:39] == 4'b0);
        word  = (load && m_age > 0) ? m_word : rd;
        wdata = m_cur[38] ? ref_align(m_cur[46:44], m_cur[1:0], word) : m_cur[31:0];
        return {m_cur[78:47], m_cur[37], m_cur[36:32], wdata};
    endfunction

    // One cycle: drive inputs after the falling edge, compare, then advance the model
    task automatic step(input logic [5:0] s, input logic [78:0] b, input logic [31:0] rd);
        logic [69:0] e;
        @(negedge clk);
        bus_if.stall           = s;
        bus_if.ex_to_mem_bus   = b;
        bus_if.data_sram_rdata = rd;
        #1;
        e       = model_out(rd);
        obs_bus = bus_if.mem_to_wb_bus;
        obs_fwd = bus_if.mem_to_id_fwd;
        check("bus", obs_bus, e);
        check("fwd", {32'b0, obs_fwd}, {32'b0, e[37:0]});
        @(posedge clk);
        if (!(s[3] && s[4])) begin
            m_cur = s[3] ? 79'b0 : b;
            m_age = 0;
        end else begin
            if (m_age == 0) m_word = rd;
            m_age++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  r27_ld  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [1:0]  r27_a   [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
        logic [31:0] r27_exp [4] = '{32'hFFFFFF80, 32'h000000F1, 32'hFFFF80F1, 32'h00007F01};
        logic [5:0]  s;
        logic [3:0]  wen;

        m_cur  = '0;
        m_age  = 1;
        m_word = '0;
        resetn = 1'b0;
        bus_if.stall           = S_RUN;
        bus_if.ex_to_mem_bus   = mk(32'h1234_0000, 3'd0, 1'b1, 4'b0, 1'b1, 1'b1, 5'd4, 32'h8);
        bus_if.data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        check("rst_bus_async", bus_if.mem_to_wb_bus, 70'b0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_bus", bus_if.mem_to_wb_bus, 70'b0);
        check("rst_fwd", {32'b0, bus_if.mem_to_id_fwd}, 70'b0);
        @(negedge clk);
        bus_if.ex_to_mem_bus = '0;
        resetn = 1'b1;

        // Plain lw
        step(S_RUN, mk(32'h1000_0040, 3'd0, 1'b1, 4'b0, 1'b1, 1'b1, 5'd5, 32'h100), $urandom);
        step(S_RUN, '0, 32'hDEADBEEF);
        check("r26_lw", obs_bus, {32'h1000_0040, 1'b1, 5'd5, 32'hDEADBEEF});

        // Byte and halfword loads
        for (int i = 0; i < 4; i++) begin
            step(S_RUN, mk(32'h2000_0000 + 32'(i * 4), r27_ld[i], 1'b1, 4'b0, 1'b1, 1'b1,
                           5'd6, 32'h200 | 32'(r27_a[i])), $urandom);
            step(S_RUN, '0, 32'h80F17F01);
            check("r27_align", {38'b0, obs_bus[31:0]}, {38'b0, r27_exp[i]});
        end

        // Held load keeps its first-cycle word
        step(S_RUN, mk(32'h3000_0000, 3'd0, 1'b1, 4'b0, 1'b1, 1'b1, 5'd7, 32'h300), $urandom);
        step(S_HOLD, '0, 32'h12345678);
        check("r28_hold0", {38'b0, obs_bus[31:0]}, {38'b0, 32'h12345678});
        for (int i = 0; i < 3; i++) begin
            step((i < 2) ? S_HOLD : S_RUN, '0, 32'hAAAAAAAA);
            check("r28_hold", {38'b0, obs_bus[31:0]}, {38'b0, 32'h12345678});
        end

        // Bubble insertion then addu
        step(S_RUN, mk(32'h4000_0000, 3'd0, 1'b1, 4'b0, 1'b1, 1'b1, 5'd8, 32'h40), $urandom);
        step(S_BUB, mk(32'h4000_0004, 3'd0, 1'b0, 4'b0, 1'b0, 1'b1, 5'd9, 32'h7), $urandom);
        step(S_RUN, mk(32'h4000_0004, 3'd0, 1'b0, 4'b0, 1'b0, 1'b1, 5'd9, 32'h7), $urandom);
        check("r29_bubble_bus", obs_bus, 70'b0);
        check("r29_bubble_fwd", {32'b0, obs_fwd}, 70'b0);
        step(S_RUN, '0, $urandom);
        check("r29_addu", obs_bus, {32'h4000_0004, 1'b1, 5'd9, 32'h7});

        // Non-load pass-through and store
        step(S_RUN, mk(32'h5000_0000, 3'd0, 1'b0, 4'b0, 1'b0, 1'b1, 5'd3, 32'hCAFE0000), $urandom);
        step(S_RUN, mk(32'h5000_0004, 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h400), $urandom);
        check("r30_pass", {38'b0, obs_bus[31:0]}, {38'b0, 32'hCAFE0000});
        step(S_HOLD, '0, $urandom);
        step(S_HOLD, '0, $urandom);
        check("r30_bufv", {69'b0, dut.buf_valid}, 70'b0);
        step(S_RUN, '0, $urandom);

        // Asynchronous reset in the middle of a held load
        step(S_RUN, mk(32'h6000_0000, 3'd0, 1'b1, 4'b0, 1'b1, 1'b1, 5'd7, 32'h500), $urandom);
        step(S_HOLD, '0, 32'h55556666);
        step(S_HOLD, '0, 32'h77778888);
        #3;
        bus_if.stall         = S_RUN;
        bus_if.ex_to_mem_bus = '0;
        resetn = 1'b0;
        #1;
        check("r31_rst_bus", bus_if.mem_to_wb_bus, 70'b0);
        check("r31_rst_fwd", {32'b0, bus_if.mem_to_id_fwd}, 70'b0);
        m_cur = '0;
        m_age = 0;
        #1;
        resetn = 1'b1;
        step(S_RUN, mk(32'h6000_0010, 3'd0, 1'b1, 4'b0, 1'b1, 1'b1, 5'd8, 32'h600), $urandom);
        step(S_RUN, '0, 32'hCCCCDDDD);
        check("r31_after", obs_bus, {32'h6000_0010, 1'b1, 5'd8, 32'hCCCCDDDD});

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned pick;
            pick = $urandom_range(0, 9);
            s = 6'($urandom);
            if (pick < 5)      s[4:3] = 2'b00;
            else if (pick < 8) s[4:3] = 2'b11;
            else               s[4:3] = 2'b01;
            if (pick == 4) s[4:3] = 2'b10;
            wen = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            step(s, mk($urandom, 3'($urandom_range(0, 7)), 1'($urandom), wen, 1'($urandom),
                       1'($urandom), 5'($urandom), $urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter EX_TO_MEM_WD, default 79, SHALL be the width of the incoming execute-to-memory bus.
REQ-002 Parameter MEM_TO_WB_WD, default 70, SHALL be the width of the outgoing memory-to-writeback bus.
REQ-003 Parameter STALL_WD, default 6, SHALL be the width of the pipeline stall vector.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port resetn, input, 1 bit: reset SHALL be asynchronous and active-low.
REQ-006 Port stall, input, STALL_WD bits: stall vector; 1 = Stop, 0 = NoStop; this stage SHALL use bits [3] (self) and [4] (writeback).
REQ-007 Port ex_to_mem_bus, input, EX_TO_MEM_WD bits, with these fields:
- pc [78:47]
- ld_type [46:44]: 0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu, others=lw.
- data_ram_en [43]
- data_ram_wen [42:39]
- sel_rf_res [38]
- rf_we [37]
- rf_waddr [36:32]
- ex_result [31:0]
REQ-008 Port data_sram_rdata, input, 32 bits: synchronous SRAM read data, valid in the first cycle a load occupies this stage.
REQ-009 Port mem_to_wb_bus, output, MEM_TO_WB_WD bits, with these fields:
- pc [69:38]
- rf_we [37]
- rf_waddr [36:32]
- rf_wdata [31:0]
REQ-010 Port mem_to_id_fwd, output, 38 bits: {rf_we, rf_waddr, rf_wdata} for decode-stage bypass; SHALL be identical to mem_to_wb_bus[37:0].

Function
REQ-011 Stage register, updated each rising edge by the first matching rule:
- stall[3]=1 and stall[4]=0: load all-zero bubble.
- stall[3]=0: load ex_to_mem_bus.
- Otherwise: hold.
REQ-012 A held instruction SHALL produce the same outputs on every held cycle.
REQ-013 Flag first_cyc SHALL be 1 in the cycle after the register loads a new instruction (including a bubble), and 0 on every subsequent hold cycle.
REQ-014 Read-data buffer, for a registered load (data_ram_en=1, data_ram_wen=0):
- When first_cyc=1, capture data_sram_rdata into rdata_buf and set buf_valid.
- buf_valid SHALL clear whenever the stage register loads new content.
REQ-015 Effective read data SHALL be rdata_buf when buf_valid=1, else data_sram_rdata (zero added latency on the first cycle).
REQ-016 Load alignment, with a = ex_result[1:0]:
- lb/lbu: select byte a; sign-extend (lb) or zero-extend (lbu) to 32 bits.
- lh/lhu: select halfword a[1]; sign-extend (lh) or zero-extend (lhu); a[0] is ignored.
- lw: full word; a is ignored.
- No misalignment exception is raised.
REQ-017 rf_wdata SHALL be the aligned load data when sel_rf_res=1, else ex_result.
REQ-018 mem_to_wb_bus pc, rf_we and rf_waddr SHALL be driven combinationally from the stage register.
REQ-019 Stores (data_ram_wen≠0) and bubbles SHALL NOT update rdata_buf.
REQ-020 A bubble SHALL produce rf_we=0.
REQ-021 Simultaneous stall[3] assertion and first_cyc SHALL still capture rdata_buf in that cycle.

Reset
REQ-022 On resetn=0, independent of clk, the following SHALL clear to 0:
- stage register
- rdata_buf
- buf_valid
- first_cyc
REQ-023 During and after reset, mem_to_wb_bus and mem_to_id_fwd SHALL be all-zero until the first non-stalled load of the register.
REQ-024 Reset asserted mid-hold SHALL discard the held instruction and its buffered data.
REQ-025 After resetn rises, the first rising edge SHALL obey REQ-011.

Verification
REQ-026 lw, ex_result=0x100, rdata=0xDEADBEEF, sel_rf_res=1, rf_waddr=5, no stall -> next cycle mem_to_wb_bus = {pc, 1, 5, 0xDEADBEEF}.
REQ-027 Byte/halfword loads with rdata=0x80F17F01 ->
- lb, a=3: 0xFFFFFF80
- lbu, a=2: 0x000000F1
- lh, a=2: 0xFFFF80F1
- lhu, a=0: 0x00007F01
REQ-028 Stall hold: lw with rdata=0x12345678 in first cycle, then stall[4:3]=11 for 3 cycles while rdata changes to 0xAAAAAAAA -> rf_wdata stays 0x12345678 all 4 cycles.
REQ-029 Bubble insertion: stall[4:3]=01 at an edge -> following cycle mem_to_wb_bus=0 and mem_to_id_fwd=0; an addu with ex_result=0x7 loaded next appears unchanged.
REQ-030 Non-load pass-through: sel_rf_res=0, ex_result=0xCAFE0000, rf_we=1 -> rf_wdata=0xCAFE0000; store (wen=4'b1111) leaves buf_valid=0.
REQ-031 Asynchronous reset: resetn pulsed low between clock edges during a held load -> outputs zero immediately; first instruction after release propagates normally.
